// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: row sequencer for the RepVGG multi-branch psum accumulator.
// Per row: take N psum beats, wait ACC_LAT cycles, hand the row downstream.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 job start pulse (honoured only when idle)
//   cfg_cin_tiles/rows    beats per row / rows per job, latched on start
//   psum_valid/ready      upstream beat handshake
//   acc_en/acc_first      accumulator update strobe / load-not-add
//   out_valid/ready       finished-row handshake
//   tile_idx/row_idx      position within the job
//   busy/done             activity flag / end-of-job pulse
module psum_acc_ctrl #(
  parameter int TILE_W  = 8,
  parameter int ROW_W   = 8,
  parameter int ACC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] cfg_cin_tiles,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic              acc_en,
  output logic              acc_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TILE_W-1:0] tile_idx,
  output logic [ROW_W-1:0]  row_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int CW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST =
    CW'((ACC_LAT > 0) ? ACC_LAT - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              done_q, done_d;

  logic st_idle, st_acc, st_wait, st_out;
  logic last_tile, last_row;

  assign st_idle = (state_q == S_IDLE);
  assign st_acc  = (state_q == S_ACC);
  assign st_wait = (state_q == S_WAIT);
  assign st_out  = (state_q == S_OUT);

  assign last_tile = (tile_q == tiles_q - 1'b1);
  assign last_row  = (row_q == rows_q - 1'b1);

  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    rows_d  = rows_q;
    tile_d  = tile_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    unique case (1'b1)
      st_idle: begin
        if (start) begin
          state_d = S_ACC;
          // a zero-sized config still runs one beat / one row
          tiles_d = (cfg_cin_tiles == '0) ?
                    TILE_W'(1) : cfg_cin_tiles;
          rows_d  = (cfg_rows == '0) ?
                    ROW_W'(1) : cfg_rows;
          tile_d  = '0;
          row_d   = '0;
        end
      end
      st_acc: begin
        if (psum_valid) begin
          if (last_tile) begin
            tile_d  = '0;
            wcnt_d  = '0;
            state_d = (ACC_LAT == 0) ? S_OUT : S_WAIT;
          end else begin
            tile_d = tile_q + 1'b1;
          end
        end
      end
      st_wait: begin
        if (wcnt_q == LAT_LAST) begin
          state_d = S_OUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      st_out: begin
        if (out_ready) begin
          if (last_row) begin
            state_d = S_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_ACC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tiles_q <= '0;
      rows_q  <= '0;
      tile_q  <= '0;
      row_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      rows_q  <= rows_d;
      tile_q  <= tile_d;
      row_q   <= row_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

  assign psum_ready = st_acc;
  assign acc_en     = psum_valid & st_acc;
  assign acc_first  = acc_en & (tile_q == '0);
  assign out_valid  = st_out;
  assign tile_idx   = tile_q;
  assign row_idx    = row_q;
  assign busy       = !st_idle;
  assign done       = done_q;

endmodule
